// File: rtl/pc_fp_unit_if.sv
// Decoder-to-PC/FP unit bundle: decoder strobes in one direction, registered
// program counter and frame state in the other.
interface pc_fp_unit_if #(
  parameter int WIDTH    = 16,
  parameter int FP_DEPTH = 8
);
  localparam int FPW = $clog2(FP_DEPTH);

  logic             cnt_en;
  logic             pc_sload;
  logic [WIDTH-1:0] new_pc;
  logic             move_fp;
  logic             push_up;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_prev;
  logic [FPW-1:0]   fp;
  logic [FPW-1:0]   depth;
  logic             fault;
  logic             fault_ovf;
  logic             fault_unf;

  modport master (
    output cnt_en, pc_sload, new_pc, move_fp, push_up,
    input  pc, pc_prev, fp, depth, fault, fault_ovf, fault_unf
  );

  modport slave (
    input  cnt_en, pc_sload, new_pc, move_fp, push_up,
    output pc, pc_prev, fp, depth, fault, fault_ovf, fault_unf
  );
endinterface

// File: rtl/pc_fp_unit.sv
// Program counter and register-frame pointer with call-depth tracking and a
// sticky overflow/underflow fault that freezes all state until reset.
module pc_fp_unit #(
  parameter int               WIDTH    = 16,
  parameter int               FP_DEPTH = 8,
  parameter logic [WIDTH-1:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  pc_fp_unit_if.slave bus
);
  localparam int             FPW       = $clog2(FP_DEPTH);
  localparam logic [FPW-1:0] MAX_DEPTH = FPW'(FP_DEPTH - 1);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_prev_q, pc_prev_d;
  logic [FPW-1:0]   depth_q, depth_d;
  logic [FPW-1:0]   fp_q, fp_d;
  logic             fault_q, fault_d;
  logic             fault_ovf_q, fault_ovf_d;
  logic             fault_unf_q, fault_unf_d;
  logic             ovf_s;
  logic             unf_s;

  // Next-state: a faulting move blocks every other update in the same cycle
  always_comb begin
    pc_d        = pc_q;
    pc_prev_d   = pc_prev_q;
    depth_d     = depth_q;
    fp_d        = fp_q;
    fault_d     = fault_q;
    fault_ovf_d = fault_ovf_q;
    fault_unf_d = fault_unf_q;
    ovf_s       = bus.move_fp & ~bus.push_up & (depth_q == MAX_DEPTH);
    unf_s       = bus.move_fp &  bus.push_up & (depth_q == {FPW{1'b0}});
    if (fault_q) begin
      fault_d = 1'b1;
    end else if (ovf_s || unf_s) begin
      fault_d     = 1'b1;
      fault_ovf_d = ovf_s;
      fault_unf_d = unf_s;
    end else begin
      if (bus.pc_sload) begin
        pc_d      = bus.new_pc;
        pc_prev_d = pc_q;
      end else if (bus.cnt_en) begin
        pc_d      = pc_q + {{(WIDTH-1){1'b0}}, 1'b1};
        pc_prev_d = pc_q;
      end else begin
        pc_d      = pc_q;
      end
      if (bus.move_fp && bus.push_up) begin
        depth_d = depth_q - {{(FPW-1){1'b0}}, 1'b1};
        fp_d    = fp_q + {{(FPW-1){1'b0}}, 1'b1};
      end else if (bus.move_fp) begin
        depth_d = depth_q + {{(FPW-1){1'b0}}, 1'b1};
        fp_d    = fp_q - {{(FPW-1){1'b0}}, 1'b1};
      end else begin
        depth_d = depth_q;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      pc_prev_q   <= RESET_PC;
      depth_q     <= {FPW{1'b0}};
      fp_q        <= MAX_DEPTH;
      fault_q     <= 1'b0;
      fault_ovf_q <= 1'b0;
      fault_unf_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      pc_prev_q   <= pc_prev_d;
      depth_q     <= depth_d;
      fp_q        <= fp_d;
      fault_q     <= fault_d;
      fault_ovf_q <= fault_ovf_d;
      fault_unf_q <= fault_unf_d;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pc_prev   = pc_prev_q;
  assign bus.depth     = depth_q;
  assign bus.fp        = fp_q;
  assign bus.fault     = fault_q;
  assign bus.fault_ovf = fault_ovf_q;
  assign bus.fault_unf = fault_unf_q;
endmodule

// File: tb/tb_pc_fp_unit.sv
// Scoreboard bench for pc_fp_unit: a reference model pushes the expected state
// per driven cycle, popped and compared one edge later.
module tb_pc_fp_unit;
  typedef struct {
    logic [15:0] pc;
    logic [15:0] pc_prev;
    logic [2:0]  fp;
    logic [2:0]  depth;
    logic        f;
    logic        fo;
    logic        fu;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  exp_t sb_q[$];

  logic [15:0] m_pc, m_prev;
  logic [2:0]  m_depth;
  logic        m_f, m_fo, m_fu;

  pc_fp_unit_if #(.WIDTH(16), .FP_DEPTH(8)) bus ();

  pc_fp_unit #(.WIDTH(16), .FP_DEPTH(8), .RESET_PC(16'h0000)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_prev = 16'h0000; m_depth = 3'd0;
    m_f = 1'b0; m_fo = 1'b0; m_fu = 1'b0;
  endtask

  function automatic exp_t model_snap();
    exp_t e;
    e.pc = m_pc; e.pc_prev = m_prev; e.depth = m_depth;
    e.fp = 3'd7 - m_depth;
    e.f = m_f; e.fo = m_fo; e.fu = m_fu;
    return e;
  endfunction

  task automatic cmp_state(input string tag, input exp_t e);
    chk_val({tag, ".pc"},      {16'h0000, bus.pc},      {16'h0000, e.pc});
    chk_val({tag, ".pc_prev"}, {16'h0000, bus.pc_prev}, {16'h0000, e.pc_prev});
    chk_val({tag, ".fp"},      {29'd0, bus.fp},         {29'd0, e.fp});
    chk_val({tag, ".depth"},   {29'd0, bus.depth},      {29'd0, e.depth});
    chk_val({tag, ".fault"},   {31'd0, bus.fault},      {31'd0, e.f});
    chk_val({tag, ".ovf"},     {31'd0, bus.fault_ovf},  {31'd0, e.fo});
    chk_val({tag, ".unf"},     {31'd0, bus.fault_unf},  {31'd0, e.fu});
  endtask

  // Drive one cycle of strobes, predict, wait one edge, compare.
  task automatic step(input string tag, input logic sl, input logic cnt,
                      input logic [15:0] npc, input logic mv, input logic up);
    exp_t e;
    bus.pc_sload = sl; bus.cnt_en = cnt; bus.new_pc = npc;
    bus.move_fp = mv; bus.push_up = up;
    if (!m_f) begin
      if (mv && !up && m_depth == 3'd7) begin
        m_f = 1'b1; m_fo = 1'b1;
      end else if (mv && up && m_depth == 3'd0) begin
        m_f = 1'b1; m_fu = 1'b1;
      end else begin
        if (sl) begin
          m_prev = m_pc; m_pc = npc;
        end else if (cnt) begin
          m_prev = m_pc; m_pc = m_pc + 16'd1;
        end
        if (mv) m_depth = up ? m_depth - 3'd1 : m_depth + 3'd1;
      end
    end
    sb_q.push_back(model_snap());
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    cmp_state(tag, e);
  endtask

  // Reset pulse placed between edges; outputs must clear without a clock.
  task automatic mid_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    cmp_state(tag, model_snap());
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    bus.cnt_en = 1'b0; bus.pc_sload = 1'b0; bus.new_pc = 16'h0000;
    bus.move_fp = 1'b0; bus.push_up = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    cmp_state("reset", model_snap());
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) step("count", 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
    chk_val("count3.pc", {16'h0000, bus.pc}, 32'h0000_0003);
    chk_val("count3.prev", {16'h0000, bus.pc_prev}, 32'h0000_0002);
    step("stall", 1'b0, 1'b0, 16'h5555, 1'b0, 1'b1);

    step("load_wins", 1'b1, 1'b1, 16'h0040, 1'b0, 1'b0);
    chk_val("load_wins.pc", {16'h0000, bus.pc}, 32'h0000_0040);
    step("load_ffff", 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    step("wrap", 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
    chk_val("wrap.pc", {16'h0000, bus.pc}, 32'h0000_0000);

    step("call", 1'b1, 1'b0, 16'h0101, 1'b1, 1'b0);
    chk_val("call.fp", {29'd0, bus.fp}, 32'd6);
    step("rtn", 1'b1, 1'b0, 16'h0011, 1'b1, 1'b1);
    chk_val("rtn.pc", {16'h0000, bus.pc}, 32'h0000_0011);

    for (int i = 0; i < 7; i++) step("push", 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    chk_val("push7.fp", {29'd0, bus.fp}, 32'd0);
    step("ovf", 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    chk_val("ovf.fault_ovf", {31'd0, bus.fault_ovf}, 32'd1);
    step("frozen1", 1'b1, 1'b1, 16'hBEEF, 1'b1, 1'b1);
    step("frozen2", 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);

    mid_reset("rst_mid_ovf");
    step("post_rst", 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
    chk_val("post_rst.pc", {16'h0000, bus.pc}, 32'h0000_0001);

    step("unf", 1'b1, 1'b0, 16'h1234, 1'b1, 1'b1);
    chk_val("unf.fault_unf", {31'd0, bus.fault_unf}, 32'd1);
    chk_val("unf.pc", {16'h0000, bus.pc}, 32'h0000_0001);
    step("frozen3", 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

    mid_reset("rst_mid_unf");
    for (int i = 0; i < 60; i++) begin
      step("rand", 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           16'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
